key_load_ctrl: RTL and testbench

Upstream feeder for the 16-bit crypto key store. Accepts key material as narrow beats over a valid/ready handshake and assembles them into full key words. Issues each word to the store as a single-cycle write strobe with its data. Also provides a permanent lock and a zeroize path.

---
 rtl/key_load_pkg.sv | 29 ++
 rtl/key_word_assembler.sv | 50 +++++
 rtl/key_load_ctrl.sv | 162 ++++++++++++++++
 tb/tb_key_load_ctrl.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_load_pkg.sv
// ---------------------------------------------------------------------------
// key_load_pkg: shared types and sizing helpers for the key loader. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package key_load_pkg;

  localparam int DEF_IN_W   = 8;
  localparam int DEF_WORD_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_COMMIT  = 3'd2,
    ST_ZERO    = 3'd3,
    ST_LOCKED  = 3'd4
  } state_e;

  function automatic int beats_per_word(input int in_w, input int word_w);
    return word_w / in_w;
  endfunction

  function automatic int beat_cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_word_assembler.sv
// ---------------------------------------------------------------------------
// key_word_assembler: beat counter and LSB-first word assembly register. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module key_word_assembler
  import key_load_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [IN_W-1:0]   beat_i,
  output logic [WORD_W-1:0] word_o,
  output logic              last_beat_o
);

  localparam int BEATS = beats_per_word(IN_W, WORD_W);
  localparam int CNT_W = beat_cnt_width(BEATS);

  logic [CNT_W-1:0]  cnt_q;
  logic [WORD_W-1:0] word_q;

  assign last_beat_o = (cnt_q == CNT_W'(BEATS - 1));
  assign word_o      = word_q;

  // Clear wins over load so a discarded partial word can never be extended.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (clear_i) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (load_i) begin
      for (int k = 0; k < BEATS; k++) begin
        if (cnt_q == CNT_W'(k)) begin
          word_q[k*IN_W +: IN_W] <= beat_i;
        end
      end
      cnt_q <= last_beat_o ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/key_load_ctrl.sv
// ---------------------------------------------------------------------------
// key_load_ctrl: key-store feeder with lock and zeroize. Rev 1.0
// Optional build macro KEY_LOAD_PARITY_EN adds in_parity / err_parity.
// ---------------------------------------------------------------------------
`default_nettype none

module key_load_ctrl
  import key_load_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
`ifdef KEY_LOAD_PARITY_EN
  input  logic              in_parity,
`endif
  output logic              in_ready,
  input  logic              lock_req,
  input  logic              zeroize,
  output logic [WORD_W-1:0] key_data,
  output logic              key_write_en,
  output logic              busy,
  output logic              locked,
`ifdef KEY_LOAD_PARITY_EN
  output logic              err_parity,
`endif
  output logic              err_locked_write
);

  logic [1:0]        rst_sync_q;
  logic              rst_int_n;
  state_e            state_q;
  logic              wen_q;
  logic              lock_q;
  logic              err_lw_q;
  logic              w_accept_st;
  logic              w_beat_fire;
  logic              w_par_ok;
  logic              w_asm_load;
  logic              w_asm_clear;
  logic              w_last_beat;
  logic [WORD_W-1:0] w_word;

  // Reset asserts asynchronously everywhere but releases on a clock edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign rst_int_n = rst_sync_q[1];

`ifdef KEY_LOAD_PARITY_EN
  logic err_par_q;
  assign w_par_ok = ^{in_data, in_parity};

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      err_par_q <= 1'b0;
    end else if (w_beat_fire && !w_par_ok) begin
      err_par_q <= 1'b1;
    end
  end
  assign err_parity = err_par_q;
`else
  assign w_par_ok = 1'b1;
`endif

  assign w_accept_st = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
  assign in_ready    = rst_int_n && w_accept_st && !zeroize && !lock_req;
  assign w_beat_fire = in_valid && in_ready;
  assign w_asm_load  = w_beat_fire && w_par_ok;
  assign w_asm_clear = (state_q == ST_COMMIT) || (state_q == ST_ZERO) ||
                       (w_accept_st && (zeroize || lock_req)) ||
                       (w_beat_fire && !w_par_ok);

  key_word_assembler #(
    .IN_W   (IN_W),
    .WORD_W (WORD_W)
  ) u_asm (
    .clk         (clk),
    .rst_n       (rst_int_n),
    .load_i      (w_asm_load),
    .clear_i     (w_asm_clear),
    .beat_i      (in_data),
    .word_o      (w_word),
    .last_beat_o (w_last_beat)
  );

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q  <= ST_IDLE;
      wen_q    <= 1'b0;
      lock_q   <= 1'b0;
      err_lw_q <= 1'b0;
    end else begin
      wen_q <= 1'b0;
      if (lock_req) begin
        lock_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE, ST_COLLECT: begin
          if (zeroize) begin
            state_q <= ST_ZERO;
            wen_q   <= 1'b1;
          end else if (lock_req) begin
            state_q <= ST_LOCKED;
          end else if (w_beat_fire) begin
            if (!w_par_ok) begin
              state_q <= ST_IDLE;
            end else if (w_last_beat) begin
              state_q <= ST_COMMIT;
              wen_q   <= 1'b1;
            end else begin
              state_q <= ST_COLLECT;
            end
          end
        end
        ST_COMMIT: begin
          if (zeroize) begin
            state_q <= ST_ZERO;
            wen_q   <= 1'b1;
          end else if (lock_q || lock_req) begin
            state_q <= ST_LOCKED;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        // A held zeroize re-enters ZERO only after passing through IDLE/LOCKED.
        ST_ZERO: begin
          state_q <= (lock_q || lock_req) ? ST_LOCKED : ST_IDLE;
        end
        ST_LOCKED: begin
          if (in_valid) begin
            err_lw_q <= 1'b1;
          end
          if (zeroize) begin
            state_q <= ST_ZERO;
            wen_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign key_write_en     = wen_q;
  assign key_data         = (wen_q && (state_q == ST_COMMIT)) ? w_word : '0;
  assign busy             = (state_q == ST_COLLECT) || (state_q == ST_COMMIT) ||
                            (state_q == ST_ZERO);
  assign locked           = lock_q;
  assign err_locked_write = err_lw_q;

endmodule

`default_nettype wire

// File: tb/tb_key_load_ctrl.sv
// ---------------------------------------------------------------------------
// tb_key_load_ctrl: directed self-checking bench for key_load_ctrl. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_key_load_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        lock_req;
  logic        zeroize;
  logic [15:0] key_data;
  logic        key_write_en;
  logic        busy;
  logic        locked;
  logic        err_locked_write;
`ifdef KEY_LOAD_PARITY_EN
  logic        in_parity;
  logic        err_parity;
`endif

  int          vectors = 0;
  int          errors  = 0;
  int          wr_count = 0;
  logic [15:0] last_wr = 16'h0;

  key_load_ctrl #(
    .IN_W   (8),
    .WORD_W (16)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .in_data          (in_data),
    .in_valid         (in_valid),
`ifdef KEY_LOAD_PARITY_EN
    .in_parity        (in_parity),
`endif
    .in_ready         (in_ready),
    .lock_req         (lock_req),
    .zeroize          (zeroize),
    .key_data         (key_data),
    .key_write_en     (key_write_en),
    .busy             (busy),
    .locked           (locked),
`ifdef KEY_LOAD_PARITY_EN
    .err_parity       (err_parity),
`endif
    .err_locked_write (err_locked_write)
  );

  always #5 clk = ~clk;

  // Write log plus the rule that the data bus is zero outside write strobes.
  always @(negedge clk) begin
    if (key_write_en === 1'b1) begin
      wr_count++;
      last_wr = key_data;
    end else begin
      vectors++;
      if (key_data !== 16'h0) begin
        errors++;
        $display("FAIL idle_bus: key_data=%h expected 0000", key_data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut;
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset;
    resetn = 1'b1; in_data = 8'h0; in_valid = 1'b0; lock_req = 1'b0; zeroize = 1'b0;
`ifdef KEY_LOAD_PARITY_EN
    in_parity = 1'b0;
`endif
    #2 resetn = 1'b0;
    #1;
    vectors++;
    if ({in_ready, key_write_en, busy, locked, err_locked_write, key_data} !== 21'h0) begin
      errors++;
      $display("FAIL reset_async: rdy/wen/busy/lock/errlw/data=%b%b%b%b%b/%h expected all 0",
               in_ready, key_write_en, busy, locked, err_locked_write, key_data);
    end
    tick(); tick();
    resetn = 1'b1;
    tick();
    vectors++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_sync_release: in_ready=%b expected 0", in_ready);
    end
    tick(); tick();
    vectors++;
    if ({in_ready, busy, locked, key_write_en} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_idle: rdy/busy/lock/wen=%b%b%b%b expected 1000",
               in_ready, busy, locked, key_write_en);
    end
  endtask

  task automatic test_single_word;
    wr_count = 0;
    in_valid = 1'b1; in_data = 8'h34;
    tick();
    vectors++;
    if ({busy, key_write_en} !== 2'b10) begin
      errors++;
      $display("FAIL word_collect: busy/wen=%b%b expected 10", busy, key_write_en);
    end
    in_data = 8'h12;
    tick();
    in_valid = 1'b0;
    vectors++;
    if ({key_write_en, key_data, in_ready} !== {1'b1, 16'h1234, 1'b0}) begin
      errors++;
      $display("FAIL word_commit: wen/data/rdy=%b/%h/%b expected 1/1234/0",
               key_write_en, key_data, in_ready);
    end
    tick();
    vectors++;
    if ({key_write_en, busy, in_ready, wr_count[3:0]} !== {3'b001, 4'd1}) begin
      errors++;
      $display("FAIL word_after: wen/busy/rdy/writes=%b%b%b/%0d expected 001/1",
               key_write_en, busy, in_ready, wr_count);
    end
  endtask

  task automatic test_lock_partial;
    reset_dut();
    wr_count = 0;
    in_valid = 1'b1; in_data = 8'hAA;
    tick();
    in_valid = 1'b0; lock_req = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL lock_req_ready: in_ready=%b expected 0", in_ready);
    end
    tick();
    lock_req = 1'b0;
    vectors++;
    if ({locked, in_ready, busy, key_write_en, err_locked_write} !== 5'b10000) begin
      errors++;
      $display("FAIL lock_enter: lock/rdy/busy/wen/errlw=%b%b%b%b%b expected 10000",
               locked, in_ready, busy, key_write_en, err_locked_write);
    end
    in_valid = 1'b1; in_data = 8'h01;
    tick();
    in_data = 8'h02;
    tick();
    in_valid = 1'b0;
    tick();
    vectors++;
    if ({err_locked_write, locked, in_ready, wr_count[3:0]} !== {3'b110, 4'd0}) begin
      errors++;
      $display("FAIL lock_beats: errlw/lock/rdy/writes=%b%b%b/%0d expected 110/0",
               err_locked_write, locked, in_ready, wr_count);
    end
  endtask

  task automatic test_zeroize_locked;
    reset_dut();
    wr_count = 0;
    in_valid = 1'b1; in_data = 8'hEF;
    tick();
    in_data = 8'hBE;
    tick();
    in_valid = 1'b0; lock_req = 1'b1;
    vectors++;
    if ({key_write_en, key_data} !== {1'b1, 16'hBEEF}) begin
      errors++;
      $display("FAIL beef_commit: wen/data=%b/%h expected 1/beef", key_write_en, key_data);
    end
    tick();
    lock_req = 1'b0;
    vectors++;
    if ({locked, key_write_en, busy, in_ready} !== 4'b1000) begin
      errors++;
      $display("FAIL commit_to_lock: lock/wen/busy/rdy=%b%b%b%b expected 1000",
               locked, key_write_en, busy, in_ready);
    end
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    vectors++;
    if ({key_write_en, key_data, busy} !== {1'b1, 16'h0000, 1'b1}) begin
      errors++;
      $display("FAIL zero_locked: wen/data/busy=%b/%h/%b expected 1/0000/1",
               key_write_en, key_data, busy);
    end
    tick();
    vectors++;
    if ({key_write_en, busy, locked, in_ready, wr_count[3:0], last_wr} !==
        {4'b0010, 4'd2, 16'h0000}) begin
      errors++;
      $display("FAIL zero_back_locked: wen/busy/lock/rdy=%b%b%b%b writes=%0d last=%h expected 0010/2/0000",
               key_write_en, busy, locked, in_ready, wr_count, last_wr);
    end
  endtask

  task automatic test_zero_lock_priority;
    reset_dut();
    wr_count = 0;
    zeroize = 1'b1; lock_req = 1'b1; in_valid = 1'b1; in_data = 8'h99;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL prio_ready: in_ready=%b expected 0", in_ready);
    end
    tick();
    zeroize = 1'b0; lock_req = 1'b0; in_valid = 1'b0;
    vectors++;
    if ({key_write_en, key_data, locked, busy} !== {1'b1, 16'h0000, 2'b11}) begin
      errors++;
      $display("FAIL prio_zero: wen/data/lock/busy=%b/%h/%b%b expected 1/0000/11",
               key_write_en, key_data, locked, busy);
    end
    tick();
    vectors++;
    if ({busy, locked, err_locked_write, wr_count[3:0], last_wr} !== {3'b010, 4'd1, 16'h0}) begin
      errors++;
      $display("FAIL prio_locked: busy/lock/errlw=%b%b%b writes=%0d last=%h expected 010/1/0000",
               busy, locked, err_locked_write, wr_count, last_wr);
    end
  endtask

  task automatic test_zeroize_held;
    reset_dut();
    wr_count = 0;
    in_valid = 1'b1; in_data = 8'hAB;
    tick();
    in_valid = 1'b0; zeroize = 1'b1;
    tick();
    vectors++;
    if ({key_write_en, key_data} !== {1'b1, 16'h0}) begin
      errors++;
      $display("FAIL held_zero1: wen/data=%b/%h expected 1/0000", key_write_en, key_data);
    end
    tick();
    vectors++;
    if ({key_write_en, busy} !== 2'b00) begin
      errors++;
      $display("FAIL held_idle: wen/busy=%b%b expected 00", key_write_en, busy);
    end
    tick();
    zeroize = 1'b0;
    vectors++;
    if (key_write_en !== 1'b1) begin
      errors++;
      $display("FAIL held_zero2: wen=%b expected 1", key_write_en);
    end
    tick();
    in_valid = 1'b1; in_data = 8'h11;
    tick();
    in_data = 8'h22;
    tick();
    in_valid = 1'b0;
    vectors++;
    if ({key_write_en, key_data, wr_count[3:0], locked} !== {1'b1, 16'h2211, 4'd2, 1'b0}) begin
      errors++;
      $display("FAIL held_discard: wen/data=%b/%h writes=%0d lock=%b expected 1/2211/2/0",
               key_write_en, key_data, wr_count, locked);
    end
    tick();
  endtask

  task automatic test_reset_midword;
    reset_dut();
    wr_count = 0;
    in_valid = 1'b1; in_data = 8'h55;
    tick();
    in_valid = 1'b0;
    resetn = 1'b0;
    #1;
    vectors++;
    if ({busy, in_ready} !== 2'b00) begin
      errors++;
      $display("FAIL midword_reset: busy/rdy=%b%b expected 00", busy, in_ready);
    end
    tick();
    resetn = 1'b1;
    tick(); tick(); tick();
    in_valid = 1'b1; in_data = 8'h66;
    tick();
    in_data = 8'h77;
    tick();
    in_valid = 1'b0;
    vectors++;
    if ({key_write_en, key_data} !== {1'b1, 16'h7766}) begin
      errors++;
      $display("FAIL midword_word: wen/data=%b/%h expected 1/7766", key_write_en, key_data);
    end
    tick();
    vectors++;
    if ({wr_count[3:0], last_wr} !== {4'd1, 16'h7766}) begin
      errors++;
      $display("FAIL midword_count: writes=%0d last=%h expected 1/7766", wr_count, last_wr);
    end
    in_valid = 1'b1; in_data = 8'h01;
    tick();
    in_data = 8'h02;
    tick();
    in_valid = 1'b0;
    resetn = 1'b0;
    #1;
    vectors++;
    if ({key_write_en, key_data} !== 17'h0) begin
      errors++;
      $display("FAIL midstrobe_reset: wen/data=%b/%h expected 0/0000", key_write_en, key_data);
    end
    tick();
    resetn = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic test_back_to_back;
    logic [7:0]  beats [4];
    logic [15:0] words [2];
    int          idx;
    int          widx;
    bit          hs;
    beats[0] = 8'h34; beats[1] = 8'h12; beats[2] = 8'h78; beats[3] = 8'h56;
    words[0] = 16'h1234; words[1] = 16'h5678;
    reset_dut();
    wr_count = 0;
    idx  = 0;
    widx = 0;
    for (int cyc = 0; cyc < 20 && idx < 4; cyc++) begin
      in_valid = 1'b1;
      in_data  = beats[idx];
      hs = (in_ready === 1'b1);
      tick();
      if (hs) begin
        idx++;
        if (idx == 2 || idx == 4) begin
          vectors++;
          if ({key_write_en, key_data} !== {1'b1, words[widx]}) begin
            errors++;
            $display("FAIL b2b_word%0d: wen/data=%b/%h expected 1/%h",
                     widx, key_write_en, key_data, words[widx]);
          end
          widx++;
        end
      end
    end
    in_valid = 1'b0;
    tick();
    vectors++;
    if (idx !== 4 || wr_count !== 2) begin
      errors++;
      $display("FAIL b2b_total: beats=%0d writes=%0d expected 4/2", idx, wr_count);
    end
  endtask

`ifdef KEY_LOAD_PARITY_EN
  task automatic test_parity;
    reset_dut();
    wr_count = 0;
    in_valid = 1'b1; in_data = 8'h34; in_parity = 1'b1;
    tick();
    vectors++;
    if ({busy, err_parity} !== 2'b01) begin
      errors++;
      $display("FAIL par_bad: busy/errpar=%b%b expected 01", busy, err_parity);
    end
    in_data = 8'h12; in_parity = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    vectors++;
    if (wr_count !== 0) begin
      errors++;
      $display("FAIL par_nowrite: writes=%0d expected 0", wr_count);
    end
    reset_dut();
    in_valid = 1'b1; in_data = 8'h34; in_parity = 1'b0;
    tick();
    in_data = 8'h12; in_parity = 1'b1;
    tick();
    in_valid = 1'b0;
    vectors++;
    if ({key_write_en, key_data, err_parity} !== {1'b1, 16'h1234, 1'b0}) begin
      errors++;
      $display("FAIL par_good: wen/data/errpar=%b/%h/%b expected 1/1234/0",
               key_write_en, key_data, err_parity);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_lock_partial();
    test_zeroize_locked();
    test_zero_lock_priority();
    test_zeroize_held();
    test_reset_midword();
    test_back_to_back();
`ifdef KEY_LOAD_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
